// File: rtl/dump_window_ctrl.sv
// Frame-aware dump window sequencer: counts vsync falling edges and drives the
// dump enable plus open/close strobes for a per-frame capture resource.
module dump_window_ctrl #(
  parameter int FW       = 32,
  parameter bit LOADROM  = 1'b0,
  parameter int DL_GUARD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          downloading,
  input  logic [FW-1:0] start_frame,
  input  logic [FW-1:0] stop_frame,
  output logic [FW-1:0] frame_cnt,
  output logic          dump_en,
  output logic          dump_on,
  output logic          dump_off,
  output logic          done
);

  localparam int GW = $clog2(DL_GUARD + 1);

  typedef enum logic [2:0] {
    IDLE,
    GUARD,
    WAIT_START,
    DUMPING,
    DONE
  } state_t;

  state_t        state;
  logic          vs_l;
  logic          dl_l;
  logic [GW-1:0] guard;
  logic [FW-1:0] entry_frame;

  logic          vs_fall;
  logic          dl_fall;
  logic          dl_rise;
  logic [FW-1:0] frame_nxt;
  logic          stop_armed;
  logic          stop_hit;

  assign vs_fall   = vs_l & ~vs;
  assign dl_fall   = dl_l & ~downloading;
  assign dl_rise   = ~dl_l & downloading;
  assign frame_nxt = vs_fall ? frame_cnt + FW'(1) : frame_cnt;

  // After a ROM load there is no start frame, so a stop frame is only
  // meaningful if it lies beyond the frame count at which the window opened.
  assign stop_armed = (stop_frame != '0) &&
                      (LOADROM ? (stop_frame > entry_frame) : (stop_frame > start_frame));
  assign stop_hit   = vs_fall && stop_armed && (frame_cnt == stop_frame);

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so every branch reads the pre-edge values and outputs stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOADROM ? IDLE : WAIT_START;
      vs_l        <= 1'b0;
      dl_l        <= 1'b0;
      guard       <= '0;
      entry_frame <= '0;
      frame_cnt   <= '0;
      dump_en     <= 1'b0;
      dump_on     <= 1'b0;
      dump_off    <= 1'b0;
      done        <= 1'b0;
    end else begin
      vs_l      <= vs;
      dl_l      <= downloading;
      frame_cnt <= frame_nxt;
      dump_on   <= 1'b0;
      dump_off  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (dl_fall) begin
            guard <= GW'(DL_GUARD);
            state <= GUARD;
          end
        end

        GUARD: begin
          if (dl_rise) begin
            state <= IDLE;
          end else if (guard == GW'(1)) begin
            state       <= DUMPING;
            dump_en     <= 1'b1;
            dump_on     <= 1'b1;
            entry_frame <= frame_nxt;
          end else begin
            guard <= guard - GW'(1);
          end
        end

        WAIT_START: begin
          if (vs_fall && (frame_cnt == start_frame)) begin
            state       <= DUMPING;
            dump_en     <= 1'b1;
            dump_on     <= 1'b1;
            entry_frame <= frame_nxt;
          end
        end

        DUMPING: begin
          if (LOADROM && dl_rise) begin
            state    <= IDLE;
            dump_en  <= 1'b0;
            dump_off <= 1'b1;
          end else if (stop_hit) begin
            state    <= DONE;
            dump_en  <= 1'b0;
            dump_off <= 1'b1;
            done     <= 1'b1;
          end
        end

        DONE: begin
          done <= 1'b1;
        end

        default: begin
          state <= LOADROM ? IDLE : WAIT_START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dump_window_ctrl.sv
// Self-checking bench for dump_window_ctrl: a frame-start table, a wrap case on
// a narrow counter, and hand-written ROM-load and reset-in-window sequences.
module tb_dump_window_ctrl;

  typedef struct packed {
    logic [31:0] frame;
    logic        en;
    logic        on;
    logic        off;
    logic        done;
  } exp_t;

  typedef struct {
    int start;
    int stop;
    int nfalls;
    int open_at;   // vs fall index (1-based) after which dump_on pulses
    int close_at;  // vs fall index after which dump_off pulses, 0 = never
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs  = 1'b0;
  logic        dl  = 1'b0;
  logic [31:0] start_frame = '0;
  logic [31:0] stop_frame  = '0;

  logic [31:0] frame0, frame1;
  logic [3:0]  frame2;
  logic        en0, on0, off0, done0;
  logic        en1, on1, off1, done1;
  logic        en2, on2, off2, done2;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t sb_q[$];
  int   lat_q[$];

  always #5 clk = ~clk;

  dump_window_ctrl #(.FW(32), .LOADROM(1'b0), .DL_GUARD(16)) u0 (
    .clk(clk), .rst(rst), .vs(vs), .downloading(dl),
    .start_frame(start_frame), .stop_frame(stop_frame),
    .frame_cnt(frame0), .dump_en(en0), .dump_on(on0), .dump_off(off0), .done(done0)
  );

  dump_window_ctrl #(.FW(32), .LOADROM(1'b1), .DL_GUARD(16)) u1 (
    .clk(clk), .rst(rst), .vs(vs), .downloading(dl),
    .start_frame(start_frame), .stop_frame(stop_frame),
    .frame_cnt(frame1), .dump_en(en1), .dump_on(on1), .dump_off(off1), .done(done1)
  );

  dump_window_ctrl #(.FW(4), .LOADROM(1'b0), .DL_GUARD(16)) u2 (
    .clk(clk), .rst(rst), .vs(vs), .downloading(dl),
    .start_frame(start_frame[3:0]), .stop_frame(stop_frame[3:0]),
    .frame_cnt(frame2), .dump_en(en2), .dump_on(on2), .dump_off(off2), .done(done2)
  );

  task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic exp_t sample(input int inst);
    exp_t s;
    case (inst)
      0:       s = '{frame0, en0, on0, off0, done0};
      1:       s = '{frame1, en1, on1, off1, done1};
      default: s = '{{28'd0, frame2}, en2, on2, off2, done2};
    endcase
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    vs  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One vs pulse; expectation is queued when the falling edge is driven and
  // compared once the DUT has registered it, then strobes must be gone.
  task automatic do_fall(input int inst, input exp_t e, input string tag);
    exp_t got, ex;
    @(negedge clk) vs = 1'b1;
    repeat (3) @(negedge clk);
    vs = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    got = sample(inst);
    ex  = sb_q.pop_front();
    check_v({tag, " frame_cnt"}, got.frame, ex.frame);
    check_b({tag, " dump_en"},   got.en,    ex.en);
    check_b({tag, " dump_on"},   got.on,    ex.on);
    check_b({tag, " dump_off"},  got.off,   ex.off);
    check_b({tag, " done"},      got.done,  ex.done);
    @(negedge clk);
    got = sample(inst);
    check_b({tag, " dump_on width"},  got.on,  1'b0);
    check_b({tag, " dump_off width"}, got.off, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // Waits (bounded) for u1 to open its window and checks the cycle count.
  task automatic wait_open(input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (en1) break;
    end
    check_v({tag, " guard latency"}, cnt, lat_q.pop_front());
    check_b({tag, " dump_on at open"}, on1, 1'b1);
    @(negedge clk);
    check_b({tag, " dump_on after open"}, on1, 1'b0);
    check_b({tag, " dump_en held"}, en1, 1'b1);
  endtask

  vec_t vecs[6];

  initial begin
    exp_t e;
    int   seen;

    vecs[0] = '{start: 3, stop: 0, nfalls: 6,  open_at: 4, close_at: 0};
    vecs[1] = '{start: 2, stop: 5, nfalls: 10, open_at: 3, close_at: 6};
    vecs[2] = '{start: 4, stop: 4, nfalls: 7,  open_at: 5, close_at: 0};
    vecs[3] = '{start: 0, stop: 0, nfalls: 3,  open_at: 1, close_at: 0};
    vecs[4] = '{start: 5, stop: 2, nfalls: 7,  open_at: 6, close_at: 0};
    vecs[5] = '{start: 1, stop: 3, nfalls: 5,  open_at: 2, close_at: 4};

    // Start-frame / stop-frame table on the LOADROM=0 instance.
    foreach (vecs[v]) begin
      start_frame = vecs[v].start;
      stop_frame  = vecs[v].stop;
      do_reset();
      check_v($sformatf("v%0d reset frame_cnt", v), frame0, 32'd0);
      check_b($sformatf("v%0d reset dump_en", v), en0, 1'b0);
      check_b($sformatf("v%0d reset done", v), done0, 1'b0);
      for (int k = 1; k <= vecs[v].nfalls; k++) begin
        e.frame = k;
        e.on    = (k == vecs[v].open_at);
        e.off   = (vecs[v].close_at != 0) && (k == vecs[v].close_at);
        e.done  = (vecs[v].close_at != 0) && (k >= vecs[v].close_at);
        e.en    = (k >= vecs[v].open_at) && !e.done;
        do_fall(0, e, $sformatf("v%0d fall%0d", v, k));
      end
    end

    // Counter wrap on the 4-bit instance: window opens once, first pass only.
    start_frame = 1;
    stop_frame  = 0;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      e.frame = k % 16;
      e.on    = (k == 2);
      e.off   = 1'b0;
      e.done  = 1'b0;
      e.en    = (k >= 2);
      do_fall(2, e, $sformatf("wrap fall%0d", k));
    end

    // Reset asserted mid-window: immediate drop, no dump_off, then reopen.
    start_frame = 1;
    stop_frame  = 0;
    do_reset();
    for (int k = 1; k <= 2; k++) begin
      e = '{frame: k, en: (k >= 2), on: (k == 2), off: 1'b0, done: 1'b0};
      do_fall(0, e, $sformatf("rstwin fall%0d", k));
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_b("async rst dump_en", en0, 1'b0);
    check_v("async rst frame_cnt", frame0, 32'd0);
    check_b("async rst done", done0, 1'b0);
    check_b("async rst dump_off", off0, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_b("post rst dump_off", off0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      e = '{frame: k, en: (k >= 2), on: (k == 2), off: 1'b0, done: 1'b0};
      do_fall(0, e, $sformatf("reopen fall%0d", k));
    end

    // ROM-load mode: guard delay, re-download close, aborted guard, stop frame.
    start_frame = 0;
    stop_frame  = 0;
    dl = 1'b0;
    do_reset();
    check_b("rom reset dump_en", en1, 1'b0);
    dl = 1'b1;
    repeat (50) @(negedge clk);
    check_b("rom loading dump_en", en1, 1'b0);
    dl = 1'b0;
    lat_q.push_back(17);
    wait_open("rom load1");

    @(negedge clk) dl = 1'b1;
    @(negedge clk);
    check_b("redl dump_en", en1, 1'b0);
    check_b("redl dump_off", off1, 1'b1);
    check_b("redl done", done1, 1'b0);
    @(negedge clk);
    check_b("redl dump_off width", off1, 1'b0);

    dl = 1'b0;
    repeat (5) @(negedge clk);
    dl = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (en1 || on1) seen++;
    end
    check_v("aborted guard opens", seen, 0);

    dl = 1'b0;
    lat_q.push_back(17);
    wait_open("rom load2");

    stop_frame = 2;
    for (int k = 1; k <= 3; k++) begin
      e = '{frame: k, en: (k < 3), on: 1'b0, off: (k == 3), done: (k >= 3)};
      do_fall(1, e, $sformatf("rom stop fall%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dump_window_ctrl.md
Name: dump_window_ctrl

Overview:
Frame-aware sequencer that decides when simulation signal dumping (or any per-frame capture resource) is active. It counts frames from the falling edge of vertical sync and opens a dump window at a programmed start frame. In ROM-load mode it instead opens the window a guard interval after the download completes. It closes the window at an optional stop frame. It sits beside the game top level in the test harness and drives the dump enable/on/off strobes consumed by the dump module.

Parameters:
FW, 32, width of frame counter and start/stop frame inputs
LOADROM, 0, 1 = window opens after download ends; 0 = window opens at start_frame
DL_GUARD, 16, clk cycles to wait after downloading falls before opening the window (LOADROM=1 only); min 1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
vs  input  1  vertical sync, already in clk domain
downloading  input  1  ROM download in progress (high while loading)
start_frame  input  FW  frame number at which the window opens (LOADROM=0)
stop_frame  input  FW  frame number at which the window closes; 0 = never close
frame_cnt  output  FW  number of vs falling edges seen since reset
dump_en  output  1  high while window open
dump_on  output  1  one-cycle pulse when window opens
dump_off  output  1  one-cycle pulse when window closes
done  output  1  sticky high after window closed by stop_frame

Behaviour:
- Reset (async, rst=1): frame_cnt=0, dump_en=0, dump_on=0, dump_off=0, done=0, vs_l=0, dl_l=0, guard counter=0. State = IDLE if LOADROM=1, else WAIT_START.
- Edge detect: vs_l<=vs each cycle; vs_fall = vs_l & ~vs. dl_fall = dl_l & ~downloading, same scheme.
- frame_cnt increments by 1 on the cycle after vs_fall is detected; it wraps from all-ones to 0 with no flag.
- Start/stop comparisons at a vs_fall use the pre-increment frame_cnt value.
- States:
  - IDLE (LOADROM=1 only): on dl_fall, load guard=DL_GUARD and go to GUARD.
  - GUARD: decrement guard each cycle. At guard==1, go to DUMPING. If downloading rises, return to IDLE.
  - WAIT_START (LOADROM=0): on vs_fall with frame_cnt==start_frame, go to DUMPING.
  - DUMPING: on vs_fall with stop_frame!=0, stop_frame>start_frame and frame_cnt==stop_frame, go to DONE. With LOADROM=1, stop compares against frame_cnt only, and stop_frame is ignored if it is <= the frame_cnt at entry. If LOADROM=1 and downloading rises, go to IDLE.
  - DONE: terminal until reset; done=1.
- Outputs are registered.
  - dump_en=1 exactly in DUMPING, asserted in the same cycle as the state change.
  - dump_on pulses for the single cycle of entry into DUMPING.
  - dump_off pulses for the single cycle of exit from DUMPING, to DONE or IDLE.
  - dump_on and dump_off are never high together.
- Entry to DUMPING with start_frame==0 and LOADROM=0 happens at the first vs_fall after reset.
- When stop_frame<=start_frame (nonzero), the window never closes.
- Re-download (LOADROM=1) after DUMPING produces dump_off. A new dl_fall then re-arms the guard, and the window may open again. done is not set in this case.
- downloading has no effect when LOADROM=0.
- Reset asserted mid-window drops dump_en immediately and asynchronously, with no dump_off pulse.
- start_frame and stop_frame are sampled live; changing them mid-run takes effect at the next vs_fall.

Test Plan:
- LOADROM=0, start=3, stop=0, vs period 100 cycles -> dump_en rises one cycle after the 4th vs fall (frame_cnt 3->4 at the same time), dump_on pulses once, window stays open.
- LOADROM=0, start=2, stop=5 -> dump_en high from the 3rd vs fall to the 6th vs fall, dump_off pulse, done=1, frame_cnt keeps counting to 10 with no further strobes.
- LOADROM=1, DL_GUARD=16, downloading high 50 cycles then low -> dump_en rises exactly 16 cycles after dl_fall is detected. Then downloading high again -> dump_off pulse, state IDLE, done=0.
- LOADROM=0, start=4, stop=4 -> window opens at the 5th vs fall and never closes, done stays 0.
- FW=4, 20 vs falls -> frame_cnt wraps 15->0 and reads 4. With start=1, the window opens only once, on the first pass.
- Assert rst during DUMPING -> dump_en, frame_cnt and done are 0 in the same cycle. No dump_off pulse. After release the window reopens at the start frame.
